// File: rtl/rsa_exp_io_ctrl.sv
// Word-serial I/O controller for the 512-bit Montgomery exponentiation core.
// It loads X, E, M, R mod M and R^2 mod M from 32-bit bus words and holds them
// stable for the core. It launches the core, waits for it to finish, then
// streams the result back as 32-bit words over a valid/ready handshake.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   in_data/in_valid/in_ready    operand word input (80 words, LSW first, x,e,m,rmodm,r2modm)
//   exp_x..exp_r2modm            operand registers driven to the core
//   exp_start                    start strobe to the core
//   exp_done/exp_result          core completion level and result
//   out_data/out_valid/out_last  result word stream, out_ready from consumer
//   out_ready                    consumer accepts the current result word
//   busy                         high whenever the controller is not loading
module rsa_exp_io_ctrl #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned OP_W   = 512
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [OP_W-1:0]   exp_x,
   output logic [OP_W-1:0]   exp_e,
   output logic [OP_W-1:0]   exp_m,
   output logic [OP_W-1:0]   exp_rmodm,
   output logic [OP_W-1:0]   exp_r2modm,
   output logic              exp_start,
   input  logic              exp_done,
   input  logic [OP_W-1:0]   exp_result,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready,
   output logic              busy
);

   localparam int unsigned WPO    = OP_W / WORD_W;
   localparam int unsigned NOPS   = 5;
   localparam int unsigned NWORDS = NOPS * WPO;
   localparam int unsigned CNT_W  = 7;
   localparam int unsigned SLOT_W = $clog2(WPO);
   localparam int unsigned OPS_W  = $clog2(NOPS);

   typedef enum logic [2:0] {
      S_LOAD, S_LAUNCH1, S_GAP, S_LAUNCH2, S_RUN, S_STREAM
   } state_t;

   state_t                              r_state;
   logic [CNT_W-1:0]                    r_word_cnt;
   logic [SLOT_W-1:0]                   r_beat_cnt;
   logic [NOPS-1:0][WPO-1:0][WORD_W-1:0] r_op;
   logic [OP_W-1:0]                     r_shift;
   logic                                r_exp_start;
   logic                                r_out_valid;
   logic                                r_out_last;
   logic                                r_busy;
   logic                                r_in_ready;
   logic                                r_run_first;

   logic [OPS_W-1:0]                    w_opnd;
   logic [SLOT_W-1:0]                   w_slot;

   // Word k lands in operand k/WPO, slot k%WPO
   assign w_opnd = OPS_W'(r_word_cnt / CNT_W'(WPO));
   assign w_slot = SLOT_W'(r_word_cnt % CNT_W'(WPO));

   assign exp_x      = r_op[0];
   assign exp_e      = r_op[1];
   assign exp_m      = r_op[2];
   assign exp_rmodm  = r_op[3];
   assign exp_r2modm = r_op[4];
   assign exp_start  = r_exp_start;
   assign out_data   = r_shift[WORD_W-1:0];
   assign out_valid  = r_out_valid;
   assign out_last   = r_out_last;
   assign busy       = r_busy;
   assign in_ready   = r_in_ready;

   // Control FSM with registered outputs
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= S_LOAD;
         r_word_cnt  <= '0;
         r_beat_cnt  <= '0;
         r_op        <= '0;
         r_shift     <= '0;
         r_exp_start <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_run_first <= 1'b0;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (in_valid && r_in_ready) begin
                  r_op[w_opnd][w_slot] <= in_data;
                  if (r_word_cnt == CNT_W'(NWORDS - 1)) begin
                     r_word_cnt  <= '0;
                     r_state     <= S_LAUNCH1;
                     r_exp_start <= 1'b1;
                     r_in_ready  <= 1'b0;
                     r_busy      <= 1'b1;
                  end else begin
                     r_word_cnt <= r_word_cnt + CNT_W'(1);
                  end
               end
            end
            // A core still parked in done needs a second strobe to actually start
            S_LAUNCH1: begin
               r_exp_start <= 1'b0;
               if (exp_done) begin
                  r_state <= S_GAP;
               end else begin
                  r_state     <= S_RUN;
                  r_run_first <= 1'b1;
               end
            end
            S_GAP: begin
               r_exp_start <= 1'b1;
               r_state     <= S_LAUNCH2;
            end
            S_LAUNCH2: begin
               r_exp_start <= 1'b0;
               r_state     <= S_RUN;
               r_run_first <= 1'b1;
            end
            // First RUN cycle may still see a stale done from the previous run
            S_RUN: begin
               r_run_first <= 1'b0;
               if (!r_run_first && exp_done) begin
                  r_shift     <= exp_result;
                  r_out_valid <= 1'b1;
                  r_out_last  <= 1'b0;
                  r_beat_cnt  <= '0;
                  r_state     <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (out_ready) begin
                  r_shift <= {WORD_W'(0), r_shift[OP_W-1:WORD_W]};
                  if (r_beat_cnt == SLOT_W'(WPO - 1)) begin
                     r_beat_cnt  <= '0;
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_in_ready  <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= S_LOAD;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + SLOT_W'(1);
                     r_out_last <= (r_beat_cnt == SLOT_W'(WPO - 2));
                  end
               end
            end
            default: r_state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_exp_io_ctrl.sv
`timescale 1ns/1ps
module tb_rsa_exp_io_ctrl;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned OP_W   = 512;
   localparam int unsigned WPO    = 16;
   localparam int unsigned NW     = 80;

   logic              clk = 1'b0;
   logic              resetn;
   logic [WORD_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   exp_x, exp_e, exp_m, exp_rmodm, exp_r2modm;
   logic              exp_start;
   logic              exp_done;
   logic [OP_W-1:0]   exp_result;
   logic [WORD_W-1:0] out_data;
   logic              out_valid;
   logic              out_last;
   logic              out_ready;
   logic              busy;

   always #5 clk = ~clk;

   rsa_exp_io_ctrl #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
      .clk(clk), .resetn(resetn),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .exp_x(exp_x), .exp_e(exp_e), .exp_m(exp_m),
      .exp_rmodm(exp_rmodm), .exp_r2modm(exp_r2modm),
      .exp_start(exp_start), .exp_done(exp_done), .exp_result(exp_result),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
      .out_ready(out_ready), .busy(busy)
   );

   typedef struct packed {
      logic [31:0] d;
      logic        last;
   } beat_t;

   beat_t       sb[$];
   int          start_q[$];
   logic [31:0] words [NW];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          acc_cnt = 0, n_cyc = 0, d_cyc = 0, beats = 0;
   int          ov_rise_cyc = 0, last_acc_cyc = 0;
   logic        prev_ov = 1'b0, prev_done = 1'b0, chk_idle_next = 1'b0;
   bit          parked_q = 0;

   // Core model controls
   bit          core_stuck = 0;
   bit          core_directed = 0;
   int          core_lat = 1;
   bit          core_busy = 0;
   int          core_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_w(input string nm, input logic [OP_W-1:0] act, input logic [OP_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Behavioural core: directed pattern or weighted word sum of the operands
   function automatic logic [OP_W-1:0] core_calc();
      logic [OP_W-1:0] r;
      for (int i = 0; i < int'(WPO); i++) begin
         if (core_directed)
            r[i*WORD_W +: WORD_W] = 32'hA000_0000 + 32'(i);
         else
            r[i*WORD_W +: WORD_W] = exp_x[i*WORD_W +: WORD_W]
                                  + 32'd3  * exp_e[i*WORD_W +: WORD_W]
                                  + 32'd5  * exp_m[i*WORD_W +: WORD_W]
                                  + 32'd7  * exp_rmodm[i*WORD_W +: WORD_W]
                                  + 32'd11 * exp_r2modm[i*WORD_W +: WORD_W];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (!resetn) begin
         exp_done  <= 1'b0;
         core_busy <= 0;
      end else if (core_stuck) begin
         exp_done   <= 1'b1;
         exp_result <= core_calc();
      end else if (exp_start) begin
         if (exp_done) exp_done <= 1'b0;
         else begin
            core_busy <= 1;
            core_cnt  <= core_lat;
         end
      end else if (core_busy) begin
         if (core_cnt == 0) begin
            core_busy  <= 0;
            exp_done   <= 1'b1;
            exp_result <= core_calc();
         end else begin
            core_cnt <= core_cnt - 1;
         end
      end
   end

   // Monitor: scoreboard compare plus timing observations
   always @(negedge clk) begin
      if (!resetn) begin
         prev_ov       = 1'b0;
         chk_idle_next = 1'b0;
      end else begin
         if (chk_idle_next) begin
            chk("in_ready_after_last", 64'(in_ready), 64'(1));
            chk("out_valid_after_last", 64'(out_valid), 64'(0));
            chk_idle_next = 1'b0;
         end
         if (in_valid && in_ready) begin
            acc_cnt++;
            if (acc_cnt == int'(NW)) begin
               n_cyc   = cyc;
               acc_cnt = 0;
            end
         end
         if (exp_start) start_q.push_back(cyc);
         if (exp_done && !prev_done) d_cyc = cyc;
         if (out_valid && !prev_ov) begin
            ov_rise_cyc = cyc;
            chk("out_valid_latency", 64'(cyc), 64'(core_stuck ? n_cyc + 6 : d_cyc + 1));
         end
         if (out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_beat: out_data=%h with no expected word", out_data);
            end else begin
               chk("out_data", 64'(out_data), 64'(sb[0].d));
               chk("out_last", 64'(out_last), 64'(sb[0].last));
               if (out_ready) begin
                  void'(sb.pop_front());
                  beats++;
                  if (sb.size() == 0) begin
                     chk_idle_next = 1'b1;
                     last_acc_cyc  = cyc;
                  end
               end
            end
         end
         prev_ov = out_valid;
      end
      prev_done = exp_done;
   end

   task automatic check_idle(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_exp_start"}, 64'(exp_start), 64'(0));
      chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      chk({tag, "_out_last"}, 64'(out_last), 64'(0));
      chk_w({tag, "_exp_x"}, exp_x, '0);
      chk_w({tag, "_exp_e"}, exp_e, '0);
      chk_w({tag, "_exp_m"}, exp_m, '0);
      chk_w({tag, "_exp_rmodm"}, exp_rmodm, '0);
      chk_w({tag, "_exp_r2modm"}, exp_r2modm, '0);
   endtask

   task automatic reset_dut(input string tag);
      resetn    = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      core_stuck = 0;
      @(posedge clk); #1;
      sb.delete();
      acc_cnt  = 0;
      parked_q = 0;
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check_idle(tag);
      @(posedge clk); #1;
   endtask

   // Fill the word table and push the expected result stream
   task automatic prep(input bit directed, input bit stuck);
      for (int k = 0; k < int'(NW); k++) words[k] = directed ? 32'(k) : $urandom();
      for (int i = 0; i < int'(WPO); i++) begin
         logic [31:0] r;
         if (directed || stuck) r = 32'hA000_0000 + 32'(i);
         else r = words[i] + 32'd3 * words[WPO+i] + 32'd5 * words[2*WPO+i]
                + 32'd7 * words[3*WPO+i] + 32'd11 * words[4*WPO+i];
         sb.push_back('{d: r, last: (i == int'(WPO) - 1)});
      end
      core_directed = directed || stuck;
      core_stuck    = stuck;
      core_lat      = $urandom_range(1, 8);
      start_q.delete();
      beats = 0;
   endtask

   task automatic load_words(input bit gaps);
      int  k = 0;
      bit  acc;
      while (k < int'(NW)) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_data  = $urandom();
         end else begin
            in_valid = 1'b1;
            in_data  = words[k];
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) k++;
      end
      in_valid = 1'b0;
      // Operands are visible the cycle after the last word
      @(negedge clk);
      for (int op = 0; op < 5; op++) begin
         logic [OP_W-1:0] e;
         logic [OP_W-1:0] a;
         for (int i = 0; i < int'(WPO); i++) e[i*WORD_W +: WORD_W] = words[op*WPO+i];
         case (op)
            0: a = exp_x;
            1: a = exp_e;
            2: a = exp_m;
            3: a = exp_rmodm;
            default: a = exp_r2modm;
         endcase
         chk_w($sformatf("operand%0d", op), a, e);
      end
      @(posedge clk); #1;
   endtask

   // Drive ignored garbage on the input until the result stream begins
   task automatic wait_stream(input bit garbage);
      int guard = 0;
      while (!out_valid && guard < 200) begin
         in_valid = garbage ? 1'($urandom_range(0, 1)) : 1'b0;
         in_data  = $urandom();
         @(posedge clk); #1;
         guard++;
      end
      in_valid = 1'b0;
      if (guard >= 200) chk("timeout_out_valid", 64'(guard), 64'(0));
   endtask

   task automatic run_op(input bit directed, input bit stuck, input int bp);
      int guard = 0;
      int ph = 0;
      bit parked;
      parked = stuck || parked_q;
      prep(directed, stuck);
      load_words(!directed);
      wait_stream(!directed);
      while (sb.size() != 0 && guard < 400) begin
         case (bp)
            0:       out_ready = 1'b1;
            1:       out_ready = (ph % 4 == 0) || (ph % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         ph++;
         @(posedge clk); #1;
         guard++;
      end
      out_ready = 1'b0;
      if (guard >= 400) chk("timeout_stream", 64'(guard), 64'(0));
      @(negedge clk);
      chk("beat_count", 64'(beats), 64'(WPO));
      if (bp == 0) chk("stream_span", 64'(last_acc_cyc - ov_rise_cyc), 64'(WPO - 1));
      chk("start_pulses", 64'(start_q.size()), 64'(parked ? 2 : 1));
      if (start_q.size() > 0) chk("start1_cycle", 64'(start_q[0]), 64'(n_cyc + 1));
      if (parked && start_q.size() > 1) chk("start2_cycle", 64'(start_q[1]), 64'(n_cyc + 3));
      parked_q = 1;
      @(posedge clk); #1;
   endtask

   task automatic run_abort(input bit in_stream);
      int guard = 0;
      prep(0, 0);
      core_lat = in_stream ? 2 : 40;
      load_words(1);
      if (!in_stream) begin
         repeat (6) @(posedge clk);
         #1;
         reset_dut("abort_run");
      end else begin
         wait_stream(1);
         out_ready = 1'b1;
         while (beats < 7 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
         end
         if (guard >= 200) chk("timeout_abort", 64'(guard), 64'(0));
         reset_dut("abort_stream");
      end
   endtask

   initial begin
      resetn    = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      reset_dut("reset");
      run_op(1, 0, 0);
      run_op(0, 0, 1);
      run_op(1, 1, 0);
      run_op(0, 0, 2);
      run_abort(0);
      run_op(0, 0, 1);
      run_abort(1);
      run_op(0, 0, 0);
      for (int i = 0; i < 3; i++) run_op(0, 0, $urandom_range(0, 2));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
